// File: rtl/program_loader.sv
// Loader that assembles a framed, checksummed byte stream into 32-bit big-endian words,
// writes them to memory and releases the CPU from reset once the image is verified.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd4096,
    parameter logic [7:0]  SYNC0     = 8'h05,
    parameter logic [7:0]  SYNC1     = 8'hE2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_loaded_o
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [31:0] word_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  csum_q;
    logic [15:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] words_loaded_q;

    logic        accept;
    logic [15:0] count_d;
    logic [31:0] word_d;
    logic [7:0]  csum_d;
    logic [15:0] words_loaded_d;

    // Readiness is a pure decode of the state so the byte source never sees a combinational loop.
    assign rx_ready_o     = (state_q != WRITE) && (state_q != ERROR) && (state_q != DONE);
    assign accept         = rx_valid_i && rx_ready_o;
    assign count_d        = {count_q[15:8], rx_data_i};
    assign word_d         = {word_q[23:0], rx_data_i};
    assign csum_d         = csum_q ^ rx_data_i;
    assign words_loaded_d = words_loaded_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            count_q        <= 16'h0000;
            word_q         <= 32'h0000_0000;
            byte_idx_q     <= 2'd0;
            csum_q         <= 8'h00;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= 32'h0000_0000;
            mem_we_q       <= 1'b0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= 16'h0000;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && rx_data_i == SYNC0) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    if (accept) begin
                        if (rx_data_i == SYNC1) begin
                            state_q <= CNT_HI;
                            err_q   <= 1'b0;
                        end else if (rx_data_i != SYNC0) begin
                            state_q <= IDLE;
                        end
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        count_q[15:8] <= rx_data_i;
                        state_q       <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (count_d == 16'h0000 || count_d > MAX_WORDS) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            words_loaded_q <= 16'h0000;
                            byte_idx_q     <= 2'd0;
                            csum_q         <= 8'h00;
                            state_q        <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q     <= word_d;
                        csum_q     <= csum_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // The fourth byte launches the write with the freshly completed word.
                        if (byte_idx_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= BASE_ADDR + words_loaded_q;
                            mem_wdata_q <= word_d;
                            state_q     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    words_loaded_q <= words_loaded_d;
                    state_q        <= (words_loaded_d == count_q) ? CHK : DATA;
                end
                CHK: begin
                    if (accept) begin
                        if (rx_data_i == csum_q) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                ERROR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_we_o       = mem_we_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a frame-level model predicts every memory write and the
// final status, and a per-cycle monitor checks the write port against it.
module tb_program_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [15:0] MAXW = 16'd4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rxData = 8'h00;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic [15:0] memAddr;
    logic [31:0] memWdata;
    logic        memWe;
    logic        cpuReset;
    logic        done;
    logic        err;
    logic [15:0] wordsLoaded;

    always #5 clk = ~clk;

    program_loader dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .rx_data_i      (rxData),
        .rx_valid_i     (rxValid),
        .rx_ready_o     (rxReady),
        .mem_addr_o     (memAddr),
        .mem_wdata_o    (memWdata),
        .mem_we_o       (memWe),
        .cpu_reset_o    (cpuReset),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (wordsLoaded)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] frameWords[$];
    int          checkCount = 0;
    int          passCount = 0;
    int          cyc = 0;
    logic        prevWe = 1'b0;
    logic        expDone = 1'b0;
    logic        expErr = 1'b0;
    logic [15:0] expWords = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    // Model checksum: XOR of every data byte of the first n words.
    function automatic logic [7:0] xorOfWords(input int n);
        logic [7:0] cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            cs = cs ^ frameWords[i][31:24] ^ frameWords[i][23:16] ^ frameWords[i][15:8] ^ frameWords[i][7:0];
        end
        return cs;
    endfunction

    // Write-port monitor: every strobe must match the next predicted write and last one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (memWe) begin
                checkOutput("rx_ready during write", {31'b0, rxReady}, 32'd0);
                checkOutput("single-cycle mem_we", {31'b0, prevWe}, 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected mem_we", {31'b0, memWe}, 32'd0);
                end else begin
                    wr_t w;
                    w = expQ.pop_front();
                    checkOutput("mem_addr", {16'h0, memAddr}, {16'h0, w.addr});
                    checkOutput("mem_wdata", memWdata, w.data);
                end
            end else if (prevWe) begin
                checkOutput("rx_ready after write", {31'b0, rxReady}, 32'd1);
            end
        end
        prevWe <= memWe;
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard = 0;
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rxReady) begin
            checkOutput("rx_ready timeout", {31'b0, rxReady}, 32'd1);
            rxValid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rxValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b1;
        rxValid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        expWords = 16'h0000;
        expDone  = 1'b0;
        expErr   = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rx_ready"}, {31'b0, rxReady}, 32'd1);
        checkOutput({tag, " mem_we"}, {31'b0, memWe}, 32'd0);
        checkOutput({tag, " mem_addr"}, {16'h0, memAddr}, {16'h0, BASE});
        checkOutput({tag, " mem_wdata"}, memWdata, 32'd0);
        checkOutput({tag, " cpu_reset"}, {31'b0, cpuReset}, 32'd1);
        checkOutput({tag, " done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, " err"}, {31'b0, err}, 32'd0);
        checkOutput({tag, " words_loaded"}, {16'h0, wordsLoaded}, 32'd0);
    endtask

    // Sends one frame built from frameWords; csumArg < 0 means send the correct checksum.
    task automatic sendFrame(input logic [15:0] count, input int csumArg, input bit preamble,
                             input int maxGap, input bit checkErrClear);
        logic [7:0] goodCs;
        logic [7:0] sentCs;
        bit         countOk;
        int         startCyc;
        countOk = (count != 16'h0000) && (count <= MAXW);
        goodCs  = countOk ? xorOfWords(int'(count)) : 8'h00;
        sentCs  = (csumArg < 0) ? goodCs : csumArg[7:0];
        if (countOk) begin
            for (int i = 0; i < int'(count); i++) expQ.push_back({BASE + 16'(i), frameWords[i]});
            expWords = count;
            expDone  = (sentCs == goodCs);
            expErr   = !expDone;
        end else begin
            expDone = 1'b0;
            expErr  = 1'b1;
        end
        if (preamble) begin
            applyStimulus(8'hFF, 0);
            applyStimulus(8'h05, 0);
        end
        applyStimulus(8'h05, 0);
        applyStimulus(8'hE2, 0);
        if (checkErrClear) checkOutput("err cleared at CNT_HI", {31'b0, err}, 32'd0);
        applyStimulus(count[15:8], 0);
        applyStimulus(count[7:0], 0);
        startCyc = cyc;
        if (countOk) begin
            for (int i = 0; i < int'(count); i++) begin
                for (int k = 3; k >= 0; k--) begin
                    applyStimulus(frameWords[i][k*8 +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
                    if (i == 0 && k == 3) startCyc = cyc;
                end
            end
            applyStimulus(sentCs, 0);
            if (maxGap == 0) checkOutput("frame cycles", 32'(cyc - startCyc), 32'(5 * int'(count)));
        end
        checkOutput("done", {31'b0, done}, {31'b0, expDone});
        checkOutput("err", {31'b0, err}, {31'b0, expErr});
        checkOutput("cpu_reset", {31'b0, cpuReset}, {31'b0, !expDone});
        checkOutput("words_loaded", {16'h0, wordsLoaded}, {16'h0, expWords});
        checkOutput("pending writes", 32'(expQ.size()), 32'd0);
        if (expDone) checkOutput("rx_ready in DONE", {31'b0, rxReady}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        checkResetValues("reset");

        // Happy path; its checksum is the XOR of the eight data bytes.
        frameWords = '{32'hDEADBEEF, 32'h01234567};
        checkOutput("model checksum happy", {24'h0, xorOfWords(2)}, 32'h22);
        sendFrame(16'd2, -1, 1'b0, 0, 1'b0);
        checkOutput("happy done literal", {31'b0, done}, 32'd1);
        checkOutput("happy words literal", {16'h0, wordsLoaded}, 32'd2);
        repeat (3) @(negedge clk);
        checkOutput("done holds", {31'b0, done}, 32'd1);

        // Bad checksum, then a one-word frame straight after the error.
        doReset();
        sendFrame(16'd2, 32'h34, 1'b0, 0, 1'b0);
        checkOutput("bad csum err literal", {31'b0, err}, 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("err sticky in IDLE", {31'b0, err}, 32'd1);
        frameWords = '{32'h0000002A};
        sendFrame(16'd1, -1, 1'b0, 0, 1'b1);
        checkOutput("recovery done literal", {31'b0, done}, 32'd1);

        // Sync hunt with a junk byte and a repeated first sync byte.
        doReset();
        frameWords = '{32'h11223344};
        checkOutput("model checksum sync", {24'h0, xorOfWords(1)}, 32'h44);
        sendFrame(16'd1, -1, 1'b1, 0, 1'b0);

        // Count limits.
        doReset();
        sendFrame(16'h0000, -1, 1'b0, 0, 1'b0);
        doReset();
        sendFrame(16'h1001, -1, 1'b0, 0, 1'b0);
        doReset();
        frameWords = {};
        for (int i = 0; i < int'(MAXW); i++) frameWords.push_back(32'hA5000000 ^ (32'(i) * 32'h00010003));
        sendFrame(MAXW, -1, 1'b0, 0, 1'b0);

        // Random rx_valid gaps must not change what reaches memory.
        doReset();
        frameWords = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h13579BDF};
        sendFrame(16'd3, -1, 1'b0, 3, 1'b0);

        // Reset two data bytes into a frame, then a clean reload.
        doReset();
        applyStimulus(8'h05, 0);
        applyStimulus(8'hE2, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("mid-frame reset");
        @(negedge clk);
        reset    = 1'b0;
        expWords = 16'h0000;
        frameWords = '{32'h89ABCDEF, 32'h76543210};
        sendFrame(16'd2, -1, 1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
